// File: rtl/tx_pkt_arbiter.sv
// Packet-granular two-input arbiter sharing one ready/ready word interface.
// Grant is held from the first word through the EOP word, so packets never interleave.
module tx_pkt_arbiter #(
   parameter logic [7:0]  SR_ADDR = 8'd160,
   parameter int unsigned CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             set_stb,
   input  logic [7:0]       set_addr,
   input  logic [31:0]      set_data,
   input  logic [31:0]      in0_dat_i,
   input  logic [3:0]       in0_flags_i,
   input  logic             in0_ready_i,
   output logic             in0_ready_o,
   input  logic [31:0]      in1_dat_i,
   input  logic [3:0]       in1_flags_i,
   input  logic             in1_ready_i,
   output logic             in1_ready_o,
   output logic [31:0]      out_dat_o,
   output logic [3:0]       out_flags_o,
   output logic             out_ready_o,
   input  logic             out_ready_i,
   output logic [CNT_W-1:0] pkt_cnt0,
   output logic [CNT_W-1:0] pkt_cnt1,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

   state_t state;
   logic   en0, en1, prio0;
   logic   last_srv;
   logic   req0, req1;
   logic   xfer0, xfer1;
   logic   unused_set_data;

   assign req0  = in0_ready_i & en0;
   assign req1  = in1_ready_i & en1;
   assign xfer0 = (state == LOCK0) & in0_ready_i & out_ready_i;
   assign xfer1 = (state == LOCK1) & in1_ready_i & out_ready_i;
   assign busy  = (state != IDLE);

   assign unused_set_data = ^set_data[31:3];

   // Config register, grant state machine and per-port packet counters
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         last_srv <= 1'b1;
         en0      <= 1'b1;
         en1      <= 1'b1;
         prio0    <= 1'b0;
         pkt_cnt0 <= '0;
         pkt_cnt1 <= '0;
      end else begin
         if (set_stb && (set_addr == SR_ADDR)) begin
            en0   <= set_data[0];
            en1   <= set_data[1];
            prio0 <= set_data[2];
         end
         case (state)
            IDLE: begin
               // Port 0 wins a contest under priority or when port 1 was served last
               if (req0 && (!req1 || prio0 || last_srv))
                  state <= LOCK0;
               else if (req1)
                  state <= LOCK1;
            end
            LOCK0: begin
               if (xfer0 && in0_flags_i[1]) begin
                  state    <= IDLE;
                  last_srv <= 1'b0;
                  pkt_cnt0 <= pkt_cnt0 + CNT_W'(1);
               end
            end
            LOCK1: begin
               if (xfer1 && in1_flags_i[1]) begin
                  state    <= IDLE;
                  last_srv <= 1'b1;
                  pkt_cnt1 <= pkt_cnt1 + CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Zero-latency pass-through of the granted port; everything quiet in IDLE
   always_comb begin
      out_dat_o   = '0;
      out_flags_o = '0;
      out_ready_o = 1'b0;
      in0_ready_o = 1'b0;
      in1_ready_o = 1'b0;
      case (state)
         LOCK0: begin
            out_dat_o   = in0_dat_i;
            out_flags_o = in0_flags_i;
            out_ready_o = in0_ready_i;
            in0_ready_o = out_ready_i;
         end
         LOCK1: begin
            out_dat_o   = in1_dat_i;
            out_flags_o = in1_flags_i;
            out_ready_o = in1_ready_i;
            in1_ready_o = out_ready_i;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_tx_pkt_arbiter.sv
// Directed bench for tx_pkt_arbiter: two packet sources, one sink, hand-derived expectations.
module tb_tx_pkt_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        set_stb;
   logic [7:0]  set_addr;
   logic [31:0] set_data;
   logic [31:0] in0_dat, in1_dat;
   logic [3:0]  in0_flags, in1_flags;
   logic        in0_rdy, in1_rdy;
   logic        in0_acc, in1_acc;
   logic [31:0] out_dat;
   logic [3:0]  out_flags;
   logic        out_vld;
   logic        out_rdy;
   logic [15:0] cnt0, cnt1;
   logic        busy;

   logic [1:0]  w_cnt0, w_cnt1;
   logic        w_unused_acc0, w_unused_acc1, w_unused_vld, w_unused_busy;
   logic [31:0] w_unused_dat;
   logic [3:0]  w_unused_flags;

   int checks = 0;
   int errors = 0;

   int len0, len1, w0, w1, pk0, pk1;
   bit src0, src1, saw1;
   logic [31:0] q[$];

   always #5 clk = ~clk;

   tx_pkt_arbiter #(.SR_ADDR(8'd160), .CNT_W(16)) dut (
      .clk(clk), .rst(rst),
      .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
      .in0_dat_i(in0_dat), .in0_flags_i(in0_flags), .in0_ready_i(in0_rdy), .in0_ready_o(in0_acc),
      .in1_dat_i(in1_dat), .in1_flags_i(in1_flags), .in1_ready_i(in1_rdy), .in1_ready_o(in1_acc),
      .out_dat_o(out_dat), .out_flags_o(out_flags), .out_ready_o(out_vld), .out_ready_i(out_rdy),
      .pkt_cnt0(cnt0), .pkt_cnt1(cnt1), .busy(busy)
   );

   // Narrow-counter copy sharing all inputs, used to observe counter wrap
   tx_pkt_arbiter #(.SR_ADDR(8'd160), .CNT_W(2)) u_wrap (
      .clk(clk), .rst(rst),
      .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
      .in0_dat_i(in0_dat), .in0_flags_i(in0_flags), .in0_ready_i(in0_rdy), .in0_ready_o(w_unused_acc0),
      .in1_dat_i(in1_dat), .in1_flags_i(in1_flags), .in1_ready_i(in1_rdy), .in1_ready_o(w_unused_acc1),
      .out_dat_o(w_unused_dat), .out_flags_o(w_unused_flags), .out_ready_o(w_unused_vld), .out_ready_i(out_rdy),
      .pkt_cnt0(w_cnt0), .pkt_cnt1(w_cnt1), .busy(w_unused_busy)
   );

   function automatic logic [31:0] mkw(input int port, input int pkt, input int word);
      return {8'(port), 8'(pkt), 8'(word), 8'h5A};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive_src();
      in0_dat   = mkw(0, pk0, w0);
      in0_flags = {2'b10, 1'(w0 == len0 - 1), 1'(w0 == 0)};
      in0_rdy   = src0;
      in1_dat   = mkw(1, pk1, w1);
      in1_flags = {2'b01, 1'(w1 == len1 - 1), 1'(w1 == 0)};
      in1_rdy   = src1;
   endtask

   task automatic reset_src();
      w0 = 0; w1 = 0; pk0 = 0; pk1 = 0;
   endtask

   // One clock: record handshakes before the edge, advance the sources after it
   task automatic cycle();
      logic f0, f1;
      #1;
      f0 = in0_acc & in0_rdy;
      f1 = in1_acc & in1_rdy;
      if (out_vld && out_rdy) q.push_back(out_dat);
      if (in1_acc) saw1 = 1'b1;
      @(posedge clk);
      #1;
      if (f0) begin w0++; if (w0 == len0) begin w0 = 0; pk0++; end end
      if (f1) begin w1++; if (w1 == len1) begin w1 = 0; pk1++; end end
      drive_src();
      #1;
   endtask

   task automatic collect(input int n, input string tag);
      for (int i = 0; i < 60 && q.size() < n; i++) cycle();
      checks++;
      if (q.size() < n) begin
         errors++;
         $display("FAIL %s: observed=%0d transfers expected=%0d", tag, q.size(), n);
      end
   endtask

   task automatic write_cfg(input logic [2:0] d);
      set_stb  = 1'b1;
      set_addr = 8'd160;
      set_data = {29'd0, d};
      cycle();
      set_stb  = 1'b0;
      set_data = '0;
   endtask

   task automatic chk_pkt(input string tag, input int base, input int port, input int pkt, input int len);
      for (int i = 0; i < len; i++)
         chk(tag, (base + i < q.size()) ? q[base + i] : 32'hDEAD_DEAD, mkw(port, pkt, i));
   endtask

   initial begin
      rst = 1'b1; set_stb = 1'b0; set_addr = '0; set_data = '0; out_rdy = 1'b0;
      len0 = 4; len1 = 3; src0 = 0; src1 = 0; saw1 = 0;
      reset_src();
      drive_src();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      chk("rst_busy", 32'(busy), 0);
      chk("rst_rdy", {29'd0, in0_acc, in1_acc, out_vld}, 0);
      chk("rst_cnt", {cnt0, cnt1}, 0);
      chk("rst_dat", {out_dat[31:4], out_flags}, 0);

      // 1: single 4-word packet from port 0, one bubble cycle before grant
      out_rdy = 1'b1;
      src0 = 1;
      drive_src();
      #1;
      chk("t1_idle_busy", 32'(busy), 0);
      chk("t1_idle_acc0", 32'(in0_acc), 0);
      cycle();
      chk("t1_lock_busy", 32'(busy), 1);
      chk("t1_lock_acc0", 32'(in0_acc), 1);
      chk("t1_lock_dat", out_dat, mkw(0, 0, 0));
      chk("t1_lock_flags", 32'(out_flags), 32'h9);
      collect(4, "t1_xfer");
      chk_pkt("t1_pkt", 0, 0, 0, 4);
      chk("t1_end_busy", 32'(busy), 0);
      chk("t1_cnt0", 32'(cnt0), 1);
      src0 = 0;
      drive_src();

      // 2: round robin with both ports streaming 3-word packets
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      len0 = 3; len1 = 3;
      reset_src();
      q.delete();
      src0 = 1; src1 = 1;
      drive_src();
      collect(12, "t2_xfer");
      chk_pkt("t2_p0a", 0, 0, 0, 3);
      chk_pkt("t2_p1a", 3, 1, 0, 3);
      chk_pkt("t2_p0b", 6, 0, 1, 3);
      chk_pkt("t2_p1b", 9, 1, 1, 3);
      src0 = 0; src1 = 0;
      drive_src();
      chk("t2_cnt", {cnt0, cnt1}, {16'd2, 16'd2});

      // 3: strict priority to port 0
      write_cfg(3'b111);
      q.delete();
      src0 = 1; src1 = 1;
      drive_src();
      collect(6, "t3_xfer");
      chk_pkt("t3_p0a", 0, 0, 2, 3);
      chk_pkt("t3_p0b", 3, 0, 3, 3);
      src0 = 0;
      drive_src();
      q.delete();
      collect(3, "t3_xfer1");
      chk_pkt("t3_p1", 0, 1, 2, 3);
      src1 = 0;
      drive_src();
      chk("t3_cnt", {cnt0, cnt1}, {16'd4, 16'd3});
      chk("wrap_cnt0", 32'(w_cnt0), 0);

      // 4: disabling port 1 mid-packet lets that packet finish, then locks it out
      write_cfg(3'b011);
      q.delete();
      src1 = 1;
      drive_src();
      collect(1, "t4_first");
      write_cfg(3'b001);
      collect(3, "t4_xfer");
      chk_pkt("t4_p1", 0, 1, 3, 3);
      chk("t4_cnt1", 32'(cnt1), 4);
      chk("wrap_cnt1", 32'(w_cnt1), 0);
      q.delete();
      saw1 = 0;
      src0 = 1;
      drive_src();
      collect(6, "t4_xfer0");
      chk_pkt("t4_p0a", 0, 0, 4, 3);
      chk_pkt("t4_p0b", 3, 0, 5, 3);
      chk("t4_no_rdy1", 32'(saw1), 0);
      chk("t4_cnt", {cnt0, cnt1}, {16'd6, 16'd4});
      src0 = 0; src1 = 0;
      drive_src();

      // 5: sink stall mid-packet holds the word and loses nothing
      write_cfg(3'b011);
      q.delete();
      src0 = 1;
      drive_src();
      collect(1, "t5_first");
      out_rdy = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk("t5_stall_acc0", 32'(in0_acc), 0);
         chk("t5_stall_dat", out_dat, mkw(0, 6, 1));
      end
      chk("t5_stall_vld", 32'(out_vld), 1);
      out_rdy = 1'b1;
      collect(3, "t5_xfer");
      chk_pkt("t5_pkt", 0, 0, 6, 3);
      chk("t5_len", 32'(q.size()), 3);
      chk("t5_cnt0", 32'(cnt0), 7);
      src0 = 0;
      drive_src();

      // 6: reset during word 2 of a port-1 packet
      q.delete();
      src1 = 1;
      drive_src();
      collect(2, "t6_xfer");
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      #1;
      chk("t6_rdy", {29'd0, in0_acc, in1_acc, out_vld}, 0);
      chk("t6_busy", 32'(busy), 0);
      chk("t6_cnt", {cnt0, cnt1}, 0);
      reset_src();
      src0 = 1; src1 = 1;
      drive_src();
      cycle();
      chk("t6_grant", {30'd0, in0_acc, in1_acc}, 32'h2);
      chk("t6_dat", out_dat, mkw(0, 0, 0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/tx_pkt_arbiter.md
Name: tx_pkt_arbiter

Overview:
Packet-granular two-input arbiter in front of the TX DSP control path. It shares one buffer-pool-style read interface (32-bit data, 4-bit flags, ready/ready handshake) between two packet sources, e.g. two buffer-pool read ports feeding one tx control block. Grant is held from the first word through the EOP word, so packets are never interleaved. Port enables and arbitration mode are set through the settings bus.

Parameters:
SR_ADDR, 8'd160, settings-bus address of the config register
CNT_W, 16, width of the per-port packet counters

Ports:
clk  in  1  clock
rst  in  1  reset: synchronous, active-high
set_stb  in  1  settings strobe
set_addr  in  8  settings address
set_data  in  32  settings data
in0_dat_i  in  32  port 0 data
in0_flags_i  in  4  port 0 flags: [0]=sop, [1]=eop, [3:2]=occ
in0_ready_i  in  1  port 0 has a word
in0_ready_o  out  1  port 0 word accepted when high with in0_ready_i
in1_dat_i  in  32  port 1 data
in1_flags_i  in  4  port 1 flags, same layout as port 0
in1_ready_i  in  1  port 1 has a word
in1_ready_o  out  1  port 1 accept
out_dat_o  out  32  muxed data
out_flags_o  out  4  muxed flags
out_ready_o  out  1  word valid toward the sink
out_ready_i  in  1  sink can accept
pkt_cnt0  out  CNT_W  packets completed from port 0
pkt_cnt1  out  CNT_W  packets completed from port 1
busy  out  1  a packet is in flight (state is LOCK0 or LOCK1)

Behaviour:
- Config register, written when set_stb is high and set_addr==SR_ADDR:
  - bit0 = en0, bit1 = en1, bit2 = prio0 (strict priority to port 0).
  - Reset value is 3'b011: both enabled, round robin.
  - The write takes effect the cycle after the strobe.
  - Config changes never truncate an in-flight packet. en/prio are sampled only in IDLE.
- Requests: req0 = in0_ready_i & en0; req1 = in1_ready_i & en1.
- State machine (states IDLE, LOCK0, LOCK1; reset to IDLE):
  - IDLE, both req: port 0 if prio0, else the port that is not last_srv.
  - IDLE, one req: that port. No req: stay in IDLE.
  - IDLE -> LOCKn takes one cycle. No word transfers while in IDLE (one bubble cycle per packet).
  - LOCKn: pass-through; a transfer happens when inN_ready_i & out_ready_i.
  - LOCKn, transfer with flags[1] (eop) set: go to IDLE, set last_srv <= n, increment pkt_cntn.
- Datapath in LOCKn, combinational with zero latency:
  - out_dat_o = inN_dat_i, out_flags_o = inN_flags_i.
  - out_ready_o = inN_ready_i.
  - inN_ready_o = out_ready_i.
  - The non-granted input's ready_o is 0.
- In IDLE: out_ready_o = 0, in0_ready_o = 0, in1_ready_o = 0; out_dat_o and out_flags_o are 0.
- SOP is not checked. A word without sop while locked is forwarded as-is. Packet boundaries are defined only by eop.
- A single-word packet (sop and eop in the same word) returns to IDLE after one transfer.
- Counters wrap from 2^CNT_W-1 to 0. Both counters are cleared by rst only.
- Source deasserting ready mid-packet: stay locked and wait indefinitely. There is no timeout.
- rst mid-packet: go to IDLE, last_srv=1 (port 0 wins the first contest), counters=0, config=3'b011. All ready outputs and busy are 0 in the cycle after rst is sampled.
- Reset values: out_ready_o=0, in0_ready_o=0, in1_ready_o=0, busy=0, pkt_cnt0=0, pkt_cnt1=0, out_dat_o=0, out_flags_o=0.

Test Plan:
1. Only port 0 requests a 4-word packet, sink always ready -> grant after 1 IDLE cycle; 4 transfers with data matching; back to IDLE after the eop word; pkt_cnt0=1.
2. Both ports continuously present 3-word packets, round robin -> grant order 0,1,0,1 (first contest after reset goes to port 0); words never interleave within a packet; after 4 packets pkt_cnt0=2, pkt_cnt1=2.
3. Write config 3'b111 (prio0), both ports requesting -> port 0 wins every contest; port 1 is served only while in0_ready_i is low in IDLE.
4. Write en1=0 during a port-1 packet -> the packet completes fully; afterwards port 1 is never granted and in1_ready_o stays 0.
5. Sink stalls (out_ready_i=0 for 5 cycles) mid-packet -> in-flight ready_o held 0 and the output word is stable; the transfer resumes with no word lost or duplicated.
6. Assert rst on word 2 of a port-1 packet -> next cycle all ready outputs are 0, state is IDLE, counters are 0; the following contest goes to port 0. Separately, preload a counter to 0xFFFF and complete one packet -> counter reads 0.
